// File: rtl/npn_pkg.sv
// Shared definitions for the NPN canonicaliser: sizes, FSM states and the
// lexicographic permutation table.
package npn_pkg;

  localparam int unsigned TT_W   = 16;
  localparam int unsigned N_PERM = 24;
  localparam int unsigned N_NEG  = 16;
  localparam int unsigned N_VAR  = 4;
  localparam int unsigned PERM_W = 5;
  localparam int unsigned NEG_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEARCH,
    ST_DONE
  } state_t;

  // Entry k packs permutation k as {P(3),P(2),P(1),P(0)}, two bits each.
  localparam logic [7:0] PERM_TAB [N_PERM] = '{
    8'hE4, 8'hB4, 8'hD8, 8'h78, 8'h9C, 8'h6C,
    8'hE1, 8'hB1, 8'hC9, 8'h39, 8'h8D, 8'h2D,
    8'hD2, 8'h72, 8'hC6, 8'h36, 8'h4E, 8'h1E,
    8'h93, 8'h63, 8'h87, 8'h27, 8'h4B, 8'h1B
  };

endpackage

// File: rtl/npn_canon_if.sv
// Handshake bundle between the truth-table producer/consumer and npn_canon.
interface npn_canon_if;
  import npn_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [TT_W-1:0]   in_tt;
  logic              out_valid;
  logic              out_ready;
  logic [TT_W-1:0]   out_tt;
  logic [PERM_W-1:0] out_perm;
  logic [NEG_W-1:0]  out_neg_in;
  logic              out_neg_out;

  modport slave (
    input  in_valid, in_tt, out_ready,
    output in_ready, out_valid, out_tt, out_perm, out_neg_in, out_neg_out
  );

  modport master (
    output in_valid, in_tt, out_ready,
    input  in_ready, out_valid, out_tt, out_perm, out_neg_in, out_neg_out
  );
endinterface

// File: rtl/npn_apply.sv
// Combinational NPN transform: res[m] = tt[m'] ^ o with m'[P(i)] = m[i] ^ n[i].
module npn_apply
  import npn_pkg::*;
(
  input  logic [TT_W-1:0]   tt,
  input  logic [PERM_W-1:0] p,
  input  logic [NEG_W-1:0]  n,
  input  logic              o,
  output logic [TT_W-1:0]   res
);

  logic [7:0]       perm;
  logic [NEG_W-1:0] mv;
  logic [NEG_W-1:0] mp;

  always_comb begin
    perm = (p < PERM_W'(N_PERM)) ? PERM_TAB[p] : PERM_TAB[0];
    res  = '0;
    mv   = '0;
    mp   = '0;
    for (int m = 0; m < int'(TT_W); m++) begin
      mv = NEG_W'(m);
      mp = '0;
      for (int i = 0; i < int'(N_VAR); i++) begin
        mp[perm[2*i +: 2]] = mv[i] ^ n[i];
      end
      res[m] = tt[mp] ^ o;
    end
  end

endmodule

// File: rtl/npn_canon.sv
// Exhaustive NPN canonicaliser: scans all 384 (perm, neg_in) pairs, both output
// polarities per cycle, and keeps the earliest smallest transformed table.
module npn_canon
  import npn_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  npn_canon_if.slave  bus
);

  state_t            state_q, state_d;
  logic [TT_W-1:0]   tt_q, tt_d;
  logic [PERM_W-1:0] p_q, p_d;
  logic [NEG_W-1:0]  n_q, n_d;
  logic [TT_W-1:0]   best_tt_q, best_tt_d;
  logic [PERM_W-1:0] best_p_q, best_p_d;
  logic [NEG_W-1:0]  best_n_q, best_n_d;
  logic              best_o_q, best_o_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;

  logic [TT_W-1:0]   cand0, cand1, cand_tt;
  logic              cand_o;

  npn_apply u_apply_pos (.tt(tt_q), .p(p_q), .n(n_q), .o(1'b0), .res(cand0));
  npn_apply u_apply_neg (.tt(tt_q), .p(p_q), .n(n_q), .o(1'b1), .res(cand1));

  // Inverted polarity wins only when strictly smaller.
  assign cand_o  = (cand1 < cand0);
  assign cand_tt = cand_o ? cand1 : cand0;

  always_comb begin
    state_d     = state_q;
    tt_d        = tt_q;
    p_d         = p_q;
    n_d         = n_q;
    best_tt_d   = best_tt_q;
    best_p_d    = best_p_q;
    best_n_d    = best_n_q;
    best_o_d    = best_o_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          state_d    = ST_SEARCH;
          tt_d       = bus.in_tt;
          p_d        = '0;
          n_d        = '0;
          in_ready_d = 1'b0;
        end
      end
      ST_SEARCH: begin
        if (((p_q == '0) && (n_q == '0)) || (cand_tt < best_tt_q)) begin
          best_tt_d = cand_tt;
          best_p_d  = p_q;
          best_n_d  = n_q;
          best_o_d  = cand_o;
        end
        n_d = n_q + NEG_W'(1);
        if (n_q == NEG_W'(N_NEG - 1)) begin
          p_d = p_q + PERM_W'(1);
          if (p_q == PERM_W'(N_PERM - 1)) begin
            state_d     = ST_DONE;
            out_valid_d = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (out_valid_q && bus.out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      tt_q        <= '0;
      p_q         <= '0;
      n_q         <= '0;
      best_tt_q   <= '0;
      best_p_q    <= '0;
      best_n_q    <= '0;
      best_o_q    <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tt_q        <= tt_d;
      p_q         <= p_d;
      n_q         <= n_d;
      best_tt_q   <= best_tt_d;
      best_p_q    <= best_p_d;
      best_n_q    <= best_n_d;
      best_o_q    <= best_o_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_tt      = best_tt_q;
  assign bus.out_perm    = best_p_q;
  assign bus.out_neg_in  = best_n_q;
  assign bus.out_neg_out = best_o_q;

endmodule

// File: tb/tb_npn_canon.sv
// Directed + random scoreboard bench for npn_canon against a software NPN model.
module tb_npn_canon;

  typedef struct {
    logic [15:0] tt;
    logic [4:0]  perm;
    logic [3:0]  neg_in;
    logic        neg_out;
  } res_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  res_t exp_q[$];

  npn_canon_if bus ();

  npn_canon dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: lexicographic perms outer, negation masks inner, o=0 before o=1, strict-less.
  function automatic res_t model(input logic [15:0] f);
    res_t       best;
    logic [1:0] pv [4];
    logic [3:0] mv, nv, mp;
    logic [15:0] g;
    int  idx;
    bit  first;
    best  = '{tt: 16'h0, perm: 5'd0, neg_in: 4'd0, neg_out: 1'b0};
    idx   = 0;
    first = 1'b1;
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        for (int c = 0; c < 4; c++)
          for (int d = 0; d < 4; d++) begin
            if (a != b && a != c && a != d && b != c && b != d && c != d) begin
              pv[0] = 2'(a); pv[1] = 2'(b); pv[2] = 2'(c); pv[3] = 2'(d);
              for (int n = 0; n < 16; n++) begin
                for (int o = 0; o < 2; o++) begin
                  nv = 4'(n);
                  for (int m = 0; m < 16; m++) begin
                    mv = 4'(m);
                    mp = '0;
                    for (int i = 0; i < 4; i++) mp[pv[i]] = mv[i] ^ nv[i];
                    g[m] = f[mp] ^ 1'(o);
                  end
                  if (first || g < best.tt) begin
                    best  = '{tt: g, perm: 5'(idx), neg_in: 4'(n), neg_out: 1'(o)};
                    first = 1'b0;
                  end
                end
              end
              idx++;
            end
          end
    return best;
  endfunction

  task automatic submit(input logic [15:0] tt);
    bus.in_tt    = tt;
    bus.in_valid = 1'b1;
    check("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    check("in_ready_after_accept", 32'(bus.in_ready), 32'd0);
  endtask

  // Counts edges from acceptance to out_valid; optionally wiggles the input side meanwhile.
  task automatic wait_result(input bit noise, output int cyc);
    cyc = 0;
    while (!bus.out_valid && cyc < 600) begin
      if (noise) begin
        bus.in_valid = cyc[0];
        bus.in_tt    = 16'($urandom);
      end
      tick();
      cyc++;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic collect(input string tag, input int hold);
    logic [26:0] snap;
    res_t        e;
    snap = {bus.out_valid, bus.out_tt, bus.out_perm, bus.out_neg_in, bus.out_neg_out};
    for (int k = 0; k < hold; k++) begin
      tick();
      check({tag, "_hold_stable"},
            32'({bus.out_valid, bus.out_tt, bus.out_perm, bus.out_neg_in, bus.out_neg_out}),
            32'(snap));
    end
    if (exp_q.size() == 0) begin
      check({tag, "_queue_nonempty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_out_tt"},      32'(bus.out_tt),      32'(e.tt));
      check({tag, "_out_perm"},    32'(bus.out_perm),    32'(e.perm));
      check({tag, "_out_neg_in"},  32'(bus.out_neg_in),  32'(e.neg_in));
      check({tag, "_out_neg_out"}, 32'(bus.out_neg_out), 32'(e.neg_out));
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, "_in_ready_after_hs"},  32'(bus.in_ready),  32'd1);
    check({tag, "_out_valid_after_hs"}, 32'(bus.out_valid), 32'd0);
  endtask

  task automatic run(input string tag, input logic [15:0] tt, input res_t e,
                     input int hold, input bit noise);
    int cyc;
    exp_q.push_back(e);
    submit(tt);
    wait_result(noise, cyc);
    check({tag, "_latency"}, 32'(cyc), 32'd384);
    collect(tag, hold);
  endtask

  initial begin
    logic [15:0] rtt;
    int          dummy;
    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_tt     = '0;
    bus.out_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    check("rst_in_ready",    32'(bus.in_ready),    32'd1);
    check("rst_out_valid",   32'(bus.out_valid),   32'd0);
    check("rst_out_tt",      32'(bus.out_tt),      32'd0);
    check("rst_out_perm",    32'(bus.out_perm),    32'd0);
    check("rst_out_neg_in",  32'(bus.out_neg_in),  32'd0);
    check("rst_out_neg_out", 32'(bus.out_neg_out), 32'd0);

    run("zero", 16'h0000, '{tt: 16'h0000, perm: 5'd0, neg_in: 4'h0, neg_out: 1'b0}, 0, 1'b0);
    run("ones", 16'hFFFF, '{tt: 16'h0000, perm: 5'd0, neg_in: 4'h0, neg_out: 1'b1}, 0, 1'b0);
    run("x0",   16'hAAAA, '{tt: 16'h00FF, perm: 5'd9, neg_in: 4'h0, neg_out: 1'b1}, 0, 1'b0);
    run("xor4", 16'h6996, '{tt: 16'h6996, perm: 5'd0, neg_in: 4'h0, neg_out: 1'b0}, 50, 1'b1);

    // Abort a search mid-flight; nothing from it may ever surface.
    submit(16'h6996);
    repeat (200) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_in_ready",  32'(bus.in_ready),  32'd1);
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_out_tt",    32'(bus.out_tt),    32'd0);
    dummy = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus.out_valid) dummy++;
    end
    check("abort_no_stale_valid", 32'(dummy), 32'd0);
    run("after_abort", 16'h6996, '{tt: 16'h6996, perm: 5'd0, neg_in: 4'h0, neg_out: 1'b0}, 0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      rtt = 16'($urandom);
      run($sformatf("rand%0d_%04h", r, rtt), rtt, model(rtt), 0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
